// File: rtl/pong_pkg.sv
// Shared Pong definitions: match states, winner codes, serve directions and screen size.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_TOP  = 2'b01;
  localparam logic [1:0] WIN_BOT  = 2'b10;

  localparam logic SERVE_DOWN = 1'b0;
  localparam logic SERVE_UP   = 1'b1;

  localparam int HRES = 640;
  localparam int VRES = 480;

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Frame, button, miss and control/score signals between the game sequencer and its neighbours.
interface pong_game_ctrl_if #(
  parameter int SCORE_W = 4
);
  logic               fsync;
  logic               start_btn;
  logic               pause_btn;
  logic               miss_top;
  logic               miss_bot;
  logic               obj_rst;
  logic               ball_run;
  logic               paddle_run;
  logic               serve_dir;
  logic [SCORE_W-1:0] score_top;
  logic [SCORE_W-1:0] score_bot;
  logic [1:0]         winner;
  logic [2:0]         state_o;

  modport master (
    output fsync, start_btn, pause_btn, miss_top, miss_bot,
    input  obj_rst, ball_run, paddle_run, serve_dir,
    input  score_top, score_bot, winner, state_o
  );

  modport slave (
    input  fsync, start_btn, pause_btn, miss_top, miss_bot,
    output obj_rst, ball_run, paddle_run, serve_dir,
    output score_top, score_bot, winner, state_o
  );
endinterface

// File: rtl/btn_sync_edge.sv
// Brings a raw asynchronous button into the clock domain and emits a one-cycle pulse on its rising edge.
module btn_sync_edge
  import pong_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // NOTE: sequential state uses <= so every register samples the pre-edge value of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_btn;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/pong_game_ctrl.sv
// Frame-level Pong match sequencer: owns the match FSM and scores, and drives the object reset/enables.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int WIN_SCORE    = 7,
  parameter int SCORE_W      = 4
) (
  input logic             pixel_clk,
  input logic             rst_n,
  pong_game_ctrl_if.slave bus
);

  localparam logic [7:0]         SERVE_LOAD = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0]         POINT_LOAD = 8'(POINT_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

  logic w_start_rise, w_pause_rise;
  logic r_start_flag, r_pause_flag, r_miss_top_flag, r_miss_bot_flag;
  logic w_start, w_pause, w_miss_top, w_miss_bot;

  state_t             r_state, w_state_nxt;
  logic [7:0]         r_cnt, w_cnt_nxt;
  logic [SCORE_W-1:0] r_score_top, w_score_top_nxt, w_top_inc;
  logic [SCORE_W-1:0] r_score_bot, w_score_bot_nxt, w_bot_inc;
  logic [1:0]         r_winner, w_winner_nxt;
  logic               r_serve_dir, w_serve_dir_nxt;
  logic               r_paused, w_paused_nxt;
  logic               r_obj_rst, w_obj_rst_nxt, w_obj_pulse;
  logic               r_ball_run, w_ball_run_nxt;
  logic               r_paddle_run, w_paddle_run_nxt;

  btn_sync_edge u_start_sync (
    .clk    (pixel_clk),
    .rst_n  (rst_n),
    .i_btn  (bus.start_btn),
    .o_rise (w_start_rise)
  );

  btn_sync_edge u_pause_sync (
    .clk    (pixel_clk),
    .rst_n  (rst_n),
    .i_btn  (bus.pause_btn),
    .o_rise (w_pause_rise)
  );

  // Events are sticky across the frame; one arriving on the fsync cycle itself is still honoured.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_flag    <= 1'b0;
      r_pause_flag    <= 1'b0;
      r_miss_top_flag <= 1'b0;
      r_miss_bot_flag <= 1'b0;
    end else begin
      r_start_flag    <= !bus.fsync && w_start;
      r_pause_flag    <= !bus.fsync && w_pause;
      r_miss_top_flag <= !bus.fsync && w_miss_top;
      r_miss_bot_flag <= !bus.fsync && w_miss_bot;
    end
  end

  assign w_start    = r_start_flag    | w_start_rise;
  assign w_pause    = r_pause_flag    | w_pause_rise;
  assign w_miss_top = r_miss_top_flag | bus.miss_top;
  assign w_miss_bot = r_miss_bot_flag | bus.miss_bot;

  assign w_top_inc = (&r_score_top) ? r_score_top : r_score_top + 1'b1;
  assign w_bot_inc = (&r_score_bot) ? r_score_bot : r_score_bot + 1'b1;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_score_top_nxt = r_score_top;
    w_score_bot_nxt = r_score_bot;
    w_winner_nxt    = r_winner;
    w_serve_dir_nxt = r_serve_dir;
    w_paused_nxt    = r_paused;
    w_obj_pulse     = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_score_top_nxt = '0;
          w_score_bot_nxt = '0;
          w_winner_nxt    = WIN_NONE;
          w_serve_dir_nxt = SERVE_DOWN;
          w_cnt_nxt       = SERVE_LOAD;
          w_state_nxt     = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (w_start)          w_state_nxt = ST_IDLE;
        else if (r_cnt == '0) w_state_nxt = ST_PLAY;
        else                  w_cnt_nxt   = r_cnt - 1'b1;
      end
      ST_PLAY: begin
        if (w_start) begin
          w_state_nxt = ST_IDLE;
        end else begin
          if (w_pause) w_paused_nxt = ~r_paused;
          // miss_top wins a same-frame tie; misses during a pause are dropped.
          if (!r_paused && w_miss_top) begin
            w_score_bot_nxt = w_bot_inc;
            w_serve_dir_nxt = SERVE_DOWN;
            if (w_bot_inc == WIN_VAL) begin
              w_winner_nxt = WIN_BOT;
              w_state_nxt  = ST_OVER;
            end else begin
              w_cnt_nxt   = POINT_LOAD;
              w_state_nxt = ST_POINT;
            end
          end else if (!r_paused && w_miss_bot) begin
            w_score_top_nxt = w_top_inc;
            w_serve_dir_nxt = SERVE_UP;
            if (w_top_inc == WIN_VAL) begin
              w_winner_nxt = WIN_TOP;
              w_state_nxt  = ST_OVER;
            end else begin
              w_cnt_nxt   = POINT_LOAD;
              w_state_nxt = ST_POINT;
            end
          end
        end
      end
      ST_POINT: begin
        if (w_start) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == '0) begin
          w_obj_pulse = 1'b1;
          w_cnt_nxt   = SERVE_LOAD;
          w_state_nxt = ST_SERVE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_OVER: begin
        if (w_start) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_state_nxt != ST_PLAY) w_paused_nxt = 1'b0;

    w_obj_rst_nxt    = (w_state_nxt == ST_IDLE) | w_obj_pulse;
    w_ball_run_nxt   = (w_state_nxt == ST_PLAY) & ~w_paused_nxt;
    w_paddle_run_nxt = (w_state_nxt == ST_SERVE) | w_ball_run_nxt;
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_score_top  <= '0;
      r_score_bot  <= '0;
      r_winner     <= WIN_NONE;
      r_serve_dir  <= SERVE_DOWN;
      r_paused     <= 1'b0;
      r_obj_rst    <= 1'b1;
      r_ball_run   <= 1'b0;
      r_paddle_run <= 1'b0;
    end else if (bus.fsync) begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_score_top  <= w_score_top_nxt;
      r_score_bot  <= w_score_bot_nxt;
      r_winner     <= w_winner_nxt;
      r_serve_dir  <= w_serve_dir_nxt;
      r_paused     <= w_paused_nxt;
      r_obj_rst    <= w_obj_rst_nxt;
      r_ball_run   <= w_ball_run_nxt;
      r_paddle_run <= w_paddle_run_nxt;
    end
  end

  assign bus.obj_rst    = r_obj_rst;
  assign bus.ball_run   = r_ball_run;
  assign bus.paddle_run = r_paddle_run;
  assign bus.serve_dir  = r_serve_dir;
  assign bus.score_top  = r_score_top;
  assign bus.score_bot  = r_score_bot;
  assign bus.winner     = r_winner;
  assign bus.state_o    = r_state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed and random frame-by-frame stimulus for pong_game_ctrl, checked against a frame-level match model.
module tb_pong_game_ctrl;

  localparam int SERVE_FRAMES = 3;
  localparam int POINT_FRAMES = 2;
  localparam int WIN_SCORE    = 2;
  localparam int SCORE_W      = 4;
  localparam int SCORE_MAX    = (1 << SCORE_W) - 1;

  localparam int S_IDLE  = 0;
  localparam int S_SERVE = 1;
  localparam int S_PLAY  = 2;
  localparam int S_POINT = 3;
  localparam int S_OVER  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pong_game_ctrl_if #(.SCORE_W(SCORE_W)) bus ();

  pong_game_ctrl #(
    .SERVE_FRAMES (SERVE_FRAMES),
    .POINT_FRAMES (POINT_FRAMES),
    .WIN_SCORE    (WIN_SCORE),
    .SCORE_W      (SCORE_W)
  ) dut (
    .pixel_clk (clk),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Match model: phase, frames left in the current timed phase, scores and flags.
  int m_state, m_left, m_top, m_bot, m_winner, m_dir;
  bit m_paused, m_rst_pulse;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_left = 0; m_top = 0; m_bot = 0;
    m_winner = 0; m_dir = 0; m_paused = 0; m_rst_pulse = 0;
  endtask

  task automatic score_point(input bit to_bot);
    if (to_bot) begin
      m_bot = (m_bot < SCORE_MAX) ? m_bot + 1 : m_bot;
      m_dir = 0;
    end else begin
      m_top = (m_top < SCORE_MAX) ? m_top + 1 : m_top;
      m_dir = 1;
    end
    if ((to_bot ? m_bot : m_top) == WIN_SCORE) begin
      m_winner = to_bot ? 2 : 1;
      m_state  = S_OVER;
    end else begin
      m_state = S_POINT;
      m_left  = POINT_FRAMES;
    end
    m_paused = 0;
  endtask

  task automatic model_step(input bit st, input bit pa, input bit mt, input bit mb);
    bit was_paused;
    m_rst_pulse = 0;
    if (st && m_state != S_IDLE) begin
      m_state  = S_IDLE;
      m_paused = 0;
      return;
    end
    case (m_state)
      S_IDLE: if (st) begin
        m_top = 0; m_bot = 0; m_winner = 0; m_dir = 0;
        m_state = S_SERVE; m_left = SERVE_FRAMES;
      end
      S_SERVE: begin
        m_left--;
        if (m_left == 0) begin
          m_state  = S_PLAY;
          m_paused = 0;
        end
      end
      S_PLAY: begin
        was_paused = m_paused;
        if (pa) m_paused = !m_paused;
        if (!was_paused && mt)      score_point(1'b1);
        else if (!was_paused && mb) score_point(1'b0);
      end
      S_POINT: begin
        m_left--;
        if (m_left == 0) begin
          m_state     = S_SERVE;
          m_left      = SERVE_FRAMES;
          m_rst_pulse = 1;
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_all(input string lbl);
    bit run;
    run = (m_state == S_PLAY) && !m_paused;
    check({lbl, ".state"},      bus.state_o,    m_state);
    check({lbl, ".obj_rst"},    bus.obj_rst,    (m_state == S_IDLE) || m_rst_pulse);
    check({lbl, ".ball_run"},   bus.ball_run,   run);
    check({lbl, ".paddle_run"}, bus.paddle_run, run || (m_state == S_SERVE));
    check({lbl, ".serve_dir"},  bus.serve_dir,  m_dir);
    check({lbl, ".score_top"},  bus.score_top,  m_top);
    check({lbl, ".score_bot"},  bus.score_bot,  m_bot);
    check({lbl, ".winner"},     bus.winner,     m_winner);
  endtask

  // One frame: events are injected early, buttons held long enough to cross the synchroniser, then fsync.
  task automatic frame(input string lbl, input bit st, input bit pa, input bit mt, input bit mb);
    @(negedge clk);
    bus.start_btn = st;
    bus.pause_btn = pa;
    bus.miss_top  = mt;
    bus.miss_bot  = mb;
    @(negedge clk);
    bus.miss_top = 1'b0;
    bus.miss_bot = 1'b0;
    repeat (4) @(negedge clk);
    bus.start_btn = 1'b0;
    bus.pause_btn = 1'b0;
    repeat (8) @(negedge clk);
    bus.fsync = 1'b1;
    @(negedge clk);
    bus.fsync = 1'b0;
    model_step(st, pa, mt, mb);
    check_all(lbl);
  endtask

  task automatic run_frames(input string lbl, input int n);
    for (int i = 0; i < n; i++) frame(lbl, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.fsync = 1'b0; bus.start_btn = 1'b0; bus.pause_btn = 1'b0;
    bus.miss_top = 1'b0; bus.miss_bot = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    frame("idle_no_start", 0, 0, 0, 0);
    frame("start", 1, 0, 0, 0);
    run_frames("serve", SERVE_FRAMES);

    frame("miss_top", 0, 0, 1, 0);
    run_frames("point", POINT_FRAMES + 1);
    run_frames("reserve", SERVE_FRAMES - 1);

    frame("both_miss", 0, 0, 1, 1);
    frame("over_miss", 0, 0, 0, 1);
    frame("over_start", 1, 0, 0, 0);
    frame("restart", 1, 0, 0, 0);
    run_frames("serve2", SERVE_FRAMES);

    frame("miss_bot1", 0, 0, 0, 1);
    run_frames("point2", POINT_FRAMES + SERVE_FRAMES);
    frame("miss_bot2", 0, 0, 0, 1);
    frame("over_miss2", 0, 0, 1, 0);
    frame("over_start2", 1, 0, 0, 0);
    frame("restart2", 1, 0, 0, 0);
    run_frames("serve3", SERVE_FRAMES);

    frame("pause", 0, 1, 0, 0);
    frame("paused_miss", 0, 0, 0, 1);
    frame("resume", 0, 1, 0, 0);
    frame("abort_play", 1, 0, 0, 0);
    frame("restart3", 1, 0, 0, 0);
    run_frames("serve4", SERVE_FRAMES);

    // Reset mid-frame with a miss already latched.
    @(negedge clk); bus.miss_top = 1'b1;
    @(negedge clk); bus.miss_top = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    check_all("in_reset");
    rst_n = 1'b1;
    run_frames("post_reset", 2);

    for (int i = 0; i < 300; i++) begin
      frame("rand",
            $urandom_range(15) == 0,
            $urandom_range(7) == 0,
            $urandom_range(5) == 0,
            $urandom_range(5) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
